// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: PC register, IF/ID register,
// BOOT/RUN/HALT sequencing, redirect and out-of-range handling.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] ROM_LIM = 32'(ROM_WORDS);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] pc_plus4;
  logic        out_of_range;

  assign pc_plus4     = pc_q + 32'd4;
  assign out_of_range = {2'b00, pc_q[31:2]} >= ROM_LIM;

  // Next-state: redirect beats everything, then per-state behaviour
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      instr_d = NOP;
      valid_d = 1'b0;
      state_d = RUN;
      if (redirect_pc[1:0] != 2'b00) mis_d = 1'b1;
    end else begin
      unique case (state_q)
        BOOT: begin
          valid_d = 1'b0;
          state_d = RUN;
        end
        RUN: begin
          if (stall) begin
            state_d = RUN;
          end else if (out_of_range) begin
            instr_d = NOP;
            valid_d = 1'b0;
            state_d = HALT;
          end else begin
            instr_d = rom_data;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
            cnt_d   = cnt_q + 32'd1;
          end
        end
        HALT: begin
          instr_d = NOP;
          valid_d = 1'b0;
        end
        default: state_d = BOOT;
      endcase
    end
  end

  // State and pipeline register update, async active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rom_addr     = pc_q;
  assign id_instr     = instr_q;
  assign id_pc_plus4  = pcp4_q;
  assign id_valid     = valid_q;
  assign halted       = (state_q == HALT);
  assign misalign_err = mis_q;
  assign fetch_count  = cnt_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a combinational ROM model.
// ROM word at address a is 32'hC0DE_0000 | a.
module tb_if_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        halted;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  if_fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .ROM_WORDS(32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .id_instr      (id_instr),
    .id_pc_plus4   (id_pc_plus4),
    .id_valid      (id_valid),
    .halted        (halted),
    .misalign_err  (misalign_err),
    .fetch_count   (fetch_count)
  );

  assign rom_data = 32'hC0DE_0000 | rom_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".addr"},  rom_addr, 32'h0);
    chk({tag, ".instr"}, id_instr, 32'h0);
    chk({tag, ".pcp4"},  id_pc_plus4, 32'h0);
    chk({tag, ".valid"}, {31'd0, id_valid}, 32'd0);
    chk({tag, ".halt"},  {31'd0, halted}, 32'd0);
    chk({tag, ".mis"},   {31'd0, misalign_err}, 32'd0);
    chk({tag, ".cnt"},   fetch_count, 32'd0);
  endtask

  initial begin
    reset          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #3;
    chk_zero("rst");

    @(negedge clk);
    reset = 1'b1;
    chk("boot.addr", rom_addr, 32'h0);
    tick();
    chk("boot.valid", {31'd0, id_valid}, 32'd0);
    chk("c1.addr", rom_addr, 32'h0);
    tick();
    chk("c2.valid", {31'd0, id_valid}, 32'd1);
    chk("c2.pcp4", id_pc_plus4, 32'd4);
    chk("c2.instr", id_instr, 32'hC0DE_0000);
    chk("c2.addr", rom_addr, 32'd4);
    tick();
    chk("c3.pcp4", id_pc_plus4, 32'd8);
    chk("c3.cnt", fetch_count, 32'd2);
    chk("c3.addr", rom_addr, 32'd8);
    tick();
    chk("c4.pcp4", id_pc_plus4, 32'd12);
    tick();
    chk("pc10.addr", rom_addr, 32'h10);
    chk("pc10.cnt", fetch_count, 32'd4);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stl.addr", rom_addr, 32'h10);
      chk("stl.instr", id_instr, 32'hC0DE_000C);
      chk("stl.valid", {31'd0, id_valid}, 32'd1);
      chk("stl.cnt", fetch_count, 32'd4);
    end
    stall = 1'b0;
    tick();
    chk("rel.pcp4", id_pc_plus4, 32'h14);
    chk("rel.cnt", fetch_count, 32'd5);

    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1C;
    tick();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    chk("rd.addr", rom_addr, 32'h1C);
    chk("rd.valid", {31'd0, id_valid}, 32'd0);
    chk("rd.instr", id_instr, 32'h0);
    chk("rd.cnt", fetch_count, 32'd5);
    tick();
    chk("rd1.pcp4", id_pc_plus4, 32'h20);
    chk("rd1.valid", {31'd0, id_valid}, 32'd1);
    chk("rd1.instr", id_instr, 32'hC0DE_001C);
    chk("rd1.cnt", fetch_count, 32'd6);

    redirect_valid = 1'b1;
    redirect_pc    = 32'h5E;
    tick();
    redirect_valid = 1'b0;
    chk("mis.addr", rom_addr, 32'h5C);
    chk("mis.flag", {31'd0, misalign_err}, 32'd1);
    tick();
    chk("mis1.pcp4", id_pc_plus4, 32'h60);
    chk("mis1.cnt", fetch_count, 32'd7);
    for (int i = 0; i < 8; i++) tick();
    chk("end.addr", rom_addr, 32'h80);
    chk("end.cnt", fetch_count, 32'd15);
    chk("end.halt", {31'd0, halted}, 32'd0);
    tick();
    chk("hlt.halt", {31'd0, halted}, 32'd1);
    chk("hlt.addr", rom_addr, 32'h80);
    chk("hlt.valid", {31'd0, id_valid}, 32'd0);
    chk("hlt.instr", id_instr, 32'h0);
    chk("hlt.cnt", fetch_count, 32'd15);
    stall = 1'b1;
    tick();
    stall = 1'b0;
    chk("hlt2.halt", {31'd0, halted}, 32'd1);
    chk("hlt2.addr", rom_addr, 32'h80);

    redirect_valid = 1'b1;
    redirect_pc    = 32'h38;
    tick();
    redirect_valid = 1'b0;
    chk("res.halt", {31'd0, halted}, 32'd0);
    chk("res.addr", rom_addr, 32'h38);
    chk("res.mis", {31'd0, misalign_err}, 32'd1);
    tick();
    chk("res1.valid", {31'd0, id_valid}, 32'd1);
    chk("res1.pcp4", id_pc_plus4, 32'h3C);
    chk("res1.instr", id_instr, 32'hC0DE_0038);
    chk("res1.cnt", fetch_count, 32'd16);

    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("oor.addr", rom_addr, 32'h200);
    chk("oor.halt", {31'd0, halted}, 32'd0);
    tick();
    chk("oor1.halt", {31'd0, halted}, 32'd1);
    chk("oor1.cnt", fetch_count, 32'd16);

    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("pre.addr", rom_addr, 32'h24);
    chk("pre.mis", {31'd0, misalign_err}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_zero("arst");
    tick();
    chk_zero("arst_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter ROM_WORDS, default 32, number of valid instruction words in the instruction ROM.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hazard unit hold request: freeze PC and IF/ID register.
REQ-006 redirect_valid  input  1  branch/jump/jr resolved taken this cycle.
REQ-007 redirect_pc  input  32  byte target address for the redirect.
REQ-008 rom_addr  output  32  byte address to instruction ROM, equal to current PC (combinational from PC register).
REQ-009 rom_data  input  32  instruction word returned combinationally by the ROM for rom_addr.
REQ-010 id_instr  output  32  registered instruction for the decode stage.
REQ-011 id_pc_plus4  output  32  registered PC+4 of id_instr, used for jal/jalr link and branch offset.
REQ-012 id_valid  output  1  id_instr is a real fetched instruction.
REQ-013 halted  output  1  controller is in HALT.
REQ-014 misalign_err  output  1  sticky flag: a redirect target had nonzero bits [1:0].
REQ-015 fetch_count  output  32  number of instructions delivered with id_valid=1.

Function
REQ-016 States: BOOT, RUN, HALT; encoding left to the implementation.
REQ-017 BOOT lasts exactly one cycle after reset release: PC held at RESET_PC, id_valid=0, next state RUN.
REQ-018 RUN, no stall, no redirect: id_instr<=rom_data, id_pc_plus4<=PC+4, id_valid<=1, PC<=PC+4, fetch_count+=1.
REQ-019 RUN, stall=1, redirect_valid=0: PC, id_instr, id_pc_plus4, id_valid, fetch_count all hold.
REQ-020 redirect_valid=1 (any state, overrides stall): PC<={redirect_pc[31:2],2'b00}; id_instr<=32'h0000_0000 (nop); id_valid<=0; fetch_count holds; next state RUN.
REQ-021 redirect_pc[1:0]!=0 at a redirect: misalign_err<=1, held until reset; target still truncated per REQ-020.
REQ-022 Out of range: when PC[31:2] >= ROM_WORDS in RUN with no redirect, no fetch occurs: id_instr<=nop, id_valid<=0, PC holds, next state HALT.
REQ-023 HALT: PC holds, id_valid=0, id_instr=nop, halted=1; exits only by redirect (REQ-020) or reset; stall ignored.
REQ-024 Redirect target out of range: accepted; HALT entered on the following cycle per REQ-022.
REQ-025 PC arithmetic modulo 2^32; PC+4 wraps to 0 without flag (range check of REQ-022 catches it first for ROM_WORDS < 2^30).
REQ-026 fetch_count wraps modulo 2^32.
REQ-027 rom_addr always equals PC; ROM latency is zero, so fetch-to-id_valid latency is exactly one cycle.
REQ-028 halted is combinational from state; all other outputs registered.

Reset
REQ-029 reset=0 asynchronously forces: PC=RESET_PC, state=BOOT, id_instr=0, id_pc_plus4=0, id_valid=0, misalign_err=0, fetch_count=0, halted=0.
REQ-030 Reset asserted mid-stall, mid-redirect or in HALT behaves identically to REQ-029; no pending redirect survives.
REQ-031 First rising edge with reset=1 performs the BOOT cycle; first id_valid=1 appears at the end of the second cycle after release.

Verification
REQ-032 Reset release, no stall, ROM words 0..2 -> rom_addr 0,0,4,8; id_valid 0,1,1; id_pc_plus4 4,8,12; fetch_count 2 after third cycle.
REQ-033 stall=1 for 3 cycles at PC=0x10 -> rom_addr stays 0x10, id_instr/id_valid unchanged, fetch_count unchanged; release -> next id_pc_plus4=0x14.
REQ-034 stall=1 and redirect_valid=1, redirect_pc=0x1C same cycle -> next PC=0x1C, id_valid=0, id_instr=0; following cycle id_pc_plus4=0x20, id_valid=1.
REQ-035 Sequential run to PC=0x80 with ROM_WORDS=32 -> no fetch at 0x80, halted=1 next cycle, PC held at 0x80; redirect to 0x38 -> halted=0, fetch resumes at 0x38.
REQ-036 redirect_pc=0x5E -> PC=0x5C, misalign_err=1 and stays 1 across later redirects until reset=0.
REQ-037 reset=0 asserted asynchronously between edges while PC=0x24 -> outputs reach REQ-029 values immediately without waiting for a clock edge.
